spi_slave_if: RTL and testbench



---
 rtl/spi_slave_if.sv | 167 ++++++++++++++++
 tb/tb_spi_slave_if.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// SPI Mode 0 slave front-end for the debug register bank.
// Oversamples the SPI pins on clk and handles fixed R/W + address + data frames.
module spi_slave_if #(
   parameter int unsigned NB_ADDR = 7,
   parameter int unsigned NB_DATA = 8,
   parameter int unsigned NB_SYNC = 2
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_sclk,
   input  logic               i_cs_n,
   input  logic               i_mosi,
   output logic               o_miso,
   output logic               o_miso_oe,
   output logic [NB_ADDR-1:0] o_spi_addr,
   output logic [NB_DATA-1:0] o_spi_wdata,
   output logic               o_spi_wr_en,
   input  logic [NB_DATA-1:0] i_spi_rdata,
   output logic               o_frame_err
);

   localparam int unsigned NB_CMD   = 1 + NB_ADDR;
   localparam int unsigned NB_FRAME = NB_CMD + NB_DATA;
   localparam int unsigned NB_CNT   = $clog2(NB_FRAME + 1);
   localparam logic [NB_CNT-1:0] CMD_LAST   = NB_CNT'(NB_CMD - 1);
   localparam logic [NB_CNT-1:0] FRAME_LAST = NB_CNT'(NB_FRAME - 1);

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

   logic [NB_SYNC-1:0]  r_sclk_sync;
   logic [NB_SYNC-1:0]  r_cs_sync;
   logic [NB_SYNC-1:0]  r_mosi_sync;
   logic                r_sclk_d;
   logic                r_cs_d;
   logic [NB_SYNC:0]    r_flush;
   logic                r_armed;
   state_t              r_state;
   logic [NB_CNT-1:0]   r_bit_cnt;
   logic [NB_FRAME-1:0] r_rx;
   logic [NB_DATA-1:0]  r_tx;
   logic                r_load;

   logic                w_sclk;
   logic                w_cs;
   logic                w_mosi;
   logic                w_sclk_rise;
   logic                w_sclk_fall;
   logic                w_cs_fall;
   logic                w_cs_rise;
   logic [NB_FRAME-1:0] w_rx_next;

   assign w_sclk      = r_sclk_sync[NB_SYNC-1];
   assign w_cs        = r_cs_sync[NB_SYNC-1];
   assign w_mosi      = r_mosi_sync[NB_SYNC-1];
   assign w_sclk_rise = w_sclk & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk & r_sclk_d;
   assign w_cs_fall   = ~w_cs & r_cs_d;
   assign w_cs_rise   = w_cs & ~r_cs_d;
   assign w_rx_next   = {r_rx[NB_FRAME-2:0], w_mosi};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_sclk_d    <= 1'b0;
         r_cs_d      <= 1'b1;
         r_flush     <= '0;
         r_armed     <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[NB_SYNC-2:0], i_sclk};
         r_cs_sync   <= {r_cs_sync[NB_SYNC-2:0], i_cs_n};
         r_mosi_sync <= {r_mosi_sync[NB_SYNC-2:0], i_mosi};
         r_sclk_d    <= w_sclk;
         r_cs_d      <= w_cs;
         r_flush     <= {r_flush[NB_SYNC-1:0], 1'b1};
         // Arm only once a genuinely sampled cs_n high has reached the detector,
         // so a select held low across reset never looks like a fresh cs_fall.
         if (r_flush[NB_SYNC] && w_cs)
            r_armed <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_bit_cnt   <= '0;
         r_rx        <= '0;
         r_tx        <= '0;
         r_load      <= 1'b0;
         o_miso      <= 1'b0;
         o_miso_oe   <= 1'b0;
         o_spi_addr  <= '0;
         o_spi_wdata <= '0;
         o_spi_wr_en <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         o_spi_wr_en <= 1'b0;
         o_frame_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               o_miso    <= 1'b0;
               o_miso_oe <= 1'b0;
               if (w_cs_fall && r_armed) begin
                  r_bit_cnt <= '0;
                  r_rx      <= '0;
                  o_miso_oe <= 1'b1;
                  r_state   <= S_CMD;
               end
            end
            S_CMD: begin
               o_miso <= 1'b0;
               if (w_cs_rise) begin
                  o_frame_err <= 1'b1;
                  o_miso_oe   <= 1'b0;
                  r_state     <= S_IDLE;
               end else if (w_sclk_rise) begin
                  r_rx      <= w_rx_next;
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == CMD_LAST) begin
                     o_spi_addr <= w_rx_next[NB_ADDR-1:0];
                     r_load     <= 1'b1;
                     r_state    <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               // Bank decodes spi_addr combinationally; capture its data one clk later.
               if (r_load) begin
                  r_tx   <= i_spi_rdata;
                  r_load <= 1'b0;
               end
               if (w_cs_rise) begin
                  o_frame_err <= 1'b1;
                  o_miso      <= 1'b0;
                  o_miso_oe   <= 1'b0;
                  r_load      <= 1'b0;
                  r_state     <= S_IDLE;
               end else if (w_sclk_rise) begin
                  r_rx      <= w_rx_next;
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == FRAME_LAST) begin
                     if (!w_rx_next[NB_FRAME-1]) begin
                        o_spi_wdata <= w_rx_next[NB_DATA-1:0];
                        o_spi_wr_en <= 1'b1;
                     end
                     o_miso  <= 1'b0;
                     r_state <= S_DONE;
                  end
               end else if (w_sclk_fall && !r_load) begin
                  o_miso <= r_tx[NB_DATA-1];
                  r_tx   <= {r_tx[NB_DATA-2:0], 1'b0};
               end
            end
            S_DONE: begin
               o_miso <= 1'b0;
               if (w_cs_rise) begin
                  o_miso_oe <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_if.sv
// Scoreboard bench for spi_slave_if: a bit-banged SPI master issues directed frames,
// expected bank-side events are queued and matched by an independent monitor.
module tb_spi_slave_if;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk = 1'b0;
   logic       cs_n = 1'b1;
   logic       mosi = 1'b0;
   logic       miso;
   logic       miso_oe;
   logic [6:0] spi_addr;
   logic [7:0] spi_wdata;
   logic       spi_wr_en;
   logic [7:0] spi_rdata;
   logic       frame_err;

   spi_slave_if #(.NB_ADDR(7), .NB_DATA(8), .NB_SYNC(2)) dut (
      .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
      .o_miso(miso), .o_miso_oe(miso_oe), .o_spi_addr(spi_addr),
      .o_spi_wdata(spi_wdata), .o_spi_wr_en(spi_wr_en),
      .i_spi_rdata(spi_rdata), .o_frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Register bank model: combinational read, write on the clk after the strobe.
   logic [7:0] bank [128];
   logic       bank_clr = 1'b1;
   always @(posedge clk) begin
      if (bank_clr) begin
         for (int i = 0; i < 128; i++) bank[i] <= 8'h00;
         bank[7'h20] <= 8'h3C;
      end else if (spi_wr_en)
         bank[spi_addr] <= spi_wdata;
   end
   assign spi_rdata = bank[spi_addr];

   typedef enum int {K_WR, K_ERR, K_RD} kind_t;
   typedef struct {
      kind_t      kind;
      logic [6:0] addr;
      logic [7:0] data;
   } exp_t;

   exp_t q[$];
   int   nchecks = 0;
   int   nfail = 0;
   logic [7:0] rd_obs;
   event ev_rd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pop_check(input kind_t k, input logic [6:0] a, input logic [7:0] d, input string name);
      exp_t e;
      if (q.size() == 0) begin
         nchecks++;
         nfail++;
         $display("FAIL %s: unexpected event kind=%0d addr=0x%0h data=0x%0h, none queued", name, k, a, d);
      end else begin
         e = q.pop_front();
         check({name, "_kind"}, k, e.kind);
         if (k != K_ERR) begin
            if (k == K_WR) check({name, "_addr"}, {25'd0, a}, {25'd0, e.addr});
            check({name, "_data"}, {24'd0, d}, {24'd0, e.data});
         end
      end
   endtask

   always @(negedge clk) begin
      if (spi_wr_en) pop_check(K_WR, spi_addr, spi_wdata, "wr_strobe");
      if (frame_err) pop_check(K_ERR, 7'd0, 8'd0, "frame_err");
   end

   always @(ev_rd) pop_check(K_RD, 7'd0, rd_obs, "read_data");

   function automatic exp_t mk(input kind_t k, input logic [6:0] a, input logic [7:0] d);
      exp_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      return e;
   endfunction

   // One SPI bit at sclk = clk/8; MISO is sampled as the master would, on the rise.
   task automatic spi_bit(input logic b, output logic m);
      mosi = b;
      #40 sclk = 1'b1;
      m = miso;
      #40 sclk = 1'b0;
   endtask

   task automatic frame(input logic [15:0] w, input int nbits, input string name);
      logic m;
      logic cmd_or;
      logic [7:0] rd;
      cmd_or = 1'b0;
      rd = 8'h00;
      cs_n = 1'b0;
      #40;
      for (int i = 0; i < nbits; i++) begin
         spi_bit((i < 16) ? w[15 - i] : 1'b1, m);
         if (i < 8) cmd_or = cmd_or | m;
         else if (i < 16) rd[15 - i] = m;
         if (i == 4) check({name, "_miso_oe"}, {31'd0, miso_oe}, 32'd1);
      end
      mosi = 1'b0;
      check({name, "_miso_cmd_zero"}, {31'd0, cmd_or}, 32'd0);
      #40 cs_n = 1'b1;
      #80;
      if (w[15] && nbits >= 16) begin
         rd_obs = rd;
         -> ev_rd;
      end
      #10;
   endtask

   initial begin
      logic m;
      @(negedge clk);
      repeat (4) @(negedge clk);
      check("reset_miso", {31'd0, miso}, 32'd0);
      check("reset_miso_oe", {31'd0, miso_oe}, 32'd0);
      check("reset_addr", {25'd0, spi_addr}, 32'd0);
      check("reset_wdata", {24'd0, spi_wdata}, 32'd0);
      check("reset_wr_en", {31'd0, spi_wr_en}, 32'd0);
      check("reset_frame_err", {31'd0, frame_err}, 32'd0);
      rst = 1'b0;
      bank_clr = 1'b0;
      #80;

      q.push_back(mk(K_WR, 7'h30, 8'hA5));
      frame(16'h30A5, 16, "wr30");
      check("wr30_addr", {25'd0, spi_addr}, 32'h30);
      check("wr30_wdata", {24'd0, spi_wdata}, 32'hA5);

      q.push_back(mk(K_RD, 7'h20, 8'h3C));
      frame(16'hA000, 16, "rd20");

      q.push_back(mk(K_WR, 7'h11, 8'h5A));
      frame(16'h115A, 16, "wr11");
      q.push_back(mk(K_RD, 7'h11, 8'h5A));
      frame(16'h9100, 16, "rd11");

      q.push_back(mk(K_ERR, 7'h10, 8'h00));
      frame(16'h1077, 12, "abort10");
      check("abort_wdata_kept", {24'd0, spi_wdata}, 32'h5A);
      check("abort_addr_decoded", {25'd0, spi_addr}, 32'h10);
      q.push_back(mk(K_WR, 7'h12, 8'h34));
      frame(16'h1234, 16, "wr12");

      q.push_back(mk(K_WR, 7'h31, 8'hFF));
      frame(16'h31FF, 20, "wr31_long");
      check("long_idle_oe", {31'd0, miso_oe}, 32'd0);

      // Reset during bit 10 of a write with cs_n held low throughout.
      cs_n = 1'b0;
      #40;
      for (int i = 0; i < 10; i++) spi_bit(16'h4099 >> (15 - i), m);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_miso_oe", {31'd0, miso_oe}, 32'd0);
      check("midrst_addr", {25'd0, spi_addr}, 32'd0);
      check("midrst_wdata", {24'd0, spi_wdata}, 32'd0);
      check("midrst_miso", {31'd0, miso}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         spi_bit(1'b0, m);
         if (i == 8) check("midrst_not_selected", {31'd0, miso_oe}, 32'd0);
      end
      check("midrst_addr_after", {25'd0, spi_addr}, 32'd0);
      #40 cs_n = 1'b1;
      #80;

      q.push_back(mk(K_RD, 7'h40, 8'h00));
      frame(16'hC000, 16, "rd40");
      q.push_back(mk(K_RD, 7'h31, 8'hFF));
      frame(16'hB100, 16, "rd31");

      #200;
      check("scoreboard_drained", q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
